// File: rtl/serial_addsub_if.sv
// Request/response bundle for the bit-serial adder/subtractor.
// The master drives an operation request; the slave returns status and result.
interface serial_addsub_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         a_ns;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         flag;

    modport master (
        output start, op_a, op_b, a_ns,
        input  busy, done, result, flag
    );

    modport slave (
        input  start, op_a, op_b, a_ns,
        output busy, done, result, flag
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one operand bit pair per clock, LSB first,
// through a single one-bit full adder/subtractor cell with a registered carry/borrow.

// One-bit full adder/subtractor cell. a_ns=1 adds (cout is carry),
// a_ns=0 subtracts (cin is borrow-in, cout is borrow-out).
module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);
    logic a_eff;

    // Borrow is the carry majority with the minuend bit inverted.
    assign a_eff = a ^ ~a_ns;
    assign s     = a ^ b ^ cin;
    assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);
endmodule

module serial_addsub #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_addsub_if.slave  bus
);
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  shift_a;
    logic [N-1:0]  shift_b;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_next;
    logic [N-1:0]  result_r;
    logic [CW-1:0] cnt;
    logic          op_r;
    logic          cy_r;
    logic          busy_r;
    logic          done_r;
    logic          flag_r;
    logic          s;
    logic          cout;

    fas u_fas (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (cy_r),
        .a_ns (op_r),
        .s    (s),
        .cout (cout)
    );

    // Accumulator with the current sum bit shifted in at the MSB.
    // NOTE: every always_comb output gets a full default first so no latch can form.
    always_comb begin
        acc_next        = acc >> 1;
        acc_next[N-1]   = s;
    end

    // Controller FSM with registered status, result and datapath shifting.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand shifters and op_r are left unreset; they are always loaded before use.
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            flag_r   <= 1'b0;
            cy_r     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shift_a <= bus.op_a;
                        shift_b <= bus.op_b;
                        op_r    <= bus.a_ns;
                        cy_r    <= 1'b0;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    cy_r    <= cout;
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result_r <= acc_next;
                        flag_r   <= cout;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.flag   = flag_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at N=8, plus a small random sweep at N=1, 4, 16.
module tb_serial_addsub;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    serial_addsub_if #(.N(8))  bus8  ();
    serial_addsub_if #(.N(1))  bus1  ();
    serial_addsub_if #(.N(4))  bus4  ();
    serial_addsub_if #(.N(16)) bus16 ();

    serial_addsub #(.N(8))  u_dut   (.clk(clk), .rst(rst), .bus(bus8));
    serial_addsub #(.N(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
    serial_addsub #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    serial_addsub #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] bb_a  [4] = '{8'hC8, 8'h12, 8'h7F, 8'h01};
    logic [7:0] bb_b  [4] = '{8'h64, 8'h34, 8'h01, 8'h02};
    logic       bb_ns [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {flag, result} for (a +/- b) at width n.
    function automatic logic [32:0] model(input int n, input logic [31:0] a,
                                          input logic [31:0] b, input logic ns);
        logic [32:0] sum;
        logic [31:0] mask;
        logic        f;
        mask = (32'd1 << n) - 32'd1;
        if (ns) begin
            sum = {1'b0, a & mask} + {1'b0, b & mask};
            f   = sum[n];
        end else begin
            sum = {1'b0, (a & mask) - (b & mask)};
            f   = (a & mask) < (b & mask);
        end
        return {f, sum[31:0] & mask};
    endfunction

    // Full N=8 transaction: accept, count busy cycles and latency, check result hold and outcome.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ns, input logic [7:0] exp_res, input logic exp_flag,
                          input logic [7:0] exp_prev);
        int   busy_n;
        int   lat;
        logic hold_ok;
        bus8.start = 1'b1;
        bus8.op_a  = a;
        bus8.op_b  = b;
        bus8.a_ns  = ns;
        tick();
        bus8.start = 1'b0;
        bus8.op_a  = ~a;
        bus8.op_b  = ~b;
        bus8.a_ns  = ~ns;
        busy_n  = 0;
        lat     = 0;
        hold_ok = 1'b1;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (bus8.busy === 1'b1) busy_n++;
            if (bus8.result !== exp_prev) hold_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, busy_n, 8);
        check({tag, "_result_hold"}, {31'd0, hold_ok}, 1);
        check({tag, "_done"}, {31'd0, bus8.done}, 1);
        check({tag, "_busy_at_done"}, {31'd0, bus8.busy}, 0);
        check({tag, "_result"}, {24'd0, bus8.result}, {24'd0, exp_res});
        check({tag, "_flag"}, {31'd0, bus8.flag}, {31'd0, exp_flag});
        tick();
        check({tag, "_done_pulse"}, {31'd0, bus8.done}, 0);
    endtask

    task automatic set_in(input int n, input logic st, input logic [31:0] a,
                          input logic [31:0] b, input logic ns);
        case (n)
            1: begin bus1.start = st; bus1.op_a = a[0]; bus1.op_b = b[0]; bus1.a_ns = ns; end
            4: begin bus4.start = st; bus4.op_a = a[3:0]; bus4.op_b = b[3:0]; bus4.a_ns = ns; end
            default: begin
                bus16.start = st; bus16.op_a = a[15:0]; bus16.op_b = b[15:0]; bus16.a_ns = ns;
            end
        endcase
    endtask

    function automatic logic get_done(input int n);
        return (n == 1) ? bus1.done : (n == 4) ? bus4.done : bus16.done;
    endfunction

    function automatic logic [32:0] get_out(input int n);
        if (n == 1) return {bus1.flag, 31'd0, bus1.result};
        if (n == 4) return {bus4.flag, 28'd0, bus4.result};
        return {bus16.flag, 16'd0, bus16.result};
    endfunction

    task automatic sweep_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic ns);
        int          lat;
        logic [32:0] exp;
        logic [32:0] obs;
        set_in(n, 1'b1, a, b, ns);
        tick();
        set_in(n, 1'b0, ~a, ~b, ~ns);
        lat = 0;
        while (get_done(n) !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        exp = model(n, a, b, ns);
        obs = get_out(n);
        check($sformatf("sweep%0d_latency", n), lat, n);
        check($sformatf("sweep%0d_result a=%0h b=%0h ns=%0b", n, a, b, ns), obs[31:0], exp[31:0]);
        check($sformatf("sweep%0d_flag a=%0h b=%0h ns=%0b", n, a, b, ns), {31'd0, obs[32]}, {31'd0, exp[32]});
        tick();
    endtask

    initial begin
        int          n_done;
        int          k;
        int          last;
        logic        pb;
        logic [7:0]  held;
        logic [32:0] exp;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        set_in(1, 1'b0, 0, 0, 1'b0);
        set_in(4, 1'b0, 0, 0, 1'b0);
        set_in(16, 1'b0, 0, 0, 1'b0);
        bus8.start = 1'b0;
        bus8.op_a  = '0;
        bus8.op_b  = '0;
        bus8.a_ns  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset_busy", {31'd0, bus8.busy}, 0);
        check("reset_done", {31'd0, bus8.done}, 0);
        check("reset_result", {24'd0, bus8.result}, 0);
        check("reset_flag", {31'd0, bus8.flag}, 0);
        tick();

        // Additions and subtractions with hand-computed results
        run_op("add_35_4a", 8'h35, 8'h4A, 1'b1, 8'h7F, 1'b0, 8'h00);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 8'h7F);
        run_op("add_80_80", 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 8'h00);
        run_op("sub_50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 8'h30);
        run_op("sub_33_33", 8'h33, 8'h33, 1'b0, 8'h00, 1'b0, 8'hF0);

        // Start while busy: second request at E3 is dropped
        bus8.start = 1'b1;
        bus8.op_a  = 8'h01;
        bus8.op_b  = 8'h02;
        bus8.a_ns  = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        bus8.start = 1'b1;
        bus8.op_a  = 8'hAA;
        bus8.op_b  = 8'h55;
        tick();
        bus8.start = 1'b0;
        n_done = 0;
        held   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (bus8.done === 1'b1) begin
                n_done++;
                held = bus8.result;
            end
            tick();
        end
        check("busy_start_done_count", n_done, 1);
        check("busy_start_result", {24'd0, held}, 32'h03);
        check("busy_start_hold", {24'd0, bus8.result}, 32'h03);
        run_op("after_hold", 8'h10, 8'h01, 1'b1, 8'h11, 1'b0, 8'h03);

        // Reset mid-operation with start high on the reset edge
        bus8.start = 1'b1;
        bus8.op_a  = 8'h35;
        bus8.op_b  = 8'h4A;
        bus8.a_ns  = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        rst        = 1'b1;
        bus8.start = 1'b1;
        tick();
        rst        = 1'b0;
        bus8.start = 1'b0;
        check("midrst_busy", {31'd0, bus8.busy}, 0);
        check("midrst_done", {31'd0, bus8.done}, 0);
        check("midrst_result", {24'd0, bus8.result}, 0);
        check("midrst_flag", {31'd0, bus8.flag}, 0);
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus8.done === 1'b1) n_done++;
            tick();
        end
        check("midrst_no_done", n_done, 0);
        run_op("midrst_fresh", 8'h0F, 8'h01, 1'b1, 8'h10, 1'b0, 8'h00);

        // Back-to-back with start held high
        n_done     = 0;
        k          = 0;
        last       = 0;
        pb         = bus8.busy;
        bus8.start = 1'b1;
        bus8.op_a  = bb_a[0];
        bus8.op_b  = bb_b[0];
        bus8.a_ns  = bb_ns[0];
        for (int g = 0; g < 100 && n_done < 4; g++) begin
            tick();
            if (bus8.busy === 1'b1 && pb !== 1'b1) begin
                if (k > 0) check($sformatf("b2b_spacing_%0d", k), cyc - last, 10);
                last = cyc;
                k++;
                if (k < 4) begin
                    bus8.op_a = bb_a[k];
                    bus8.op_b = bb_b[k];
                    bus8.a_ns = bb_ns[k];
                end
            end
            pb = bus8.busy;
            if (bus8.done === 1'b1) begin
                exp = model(8, {24'd0, bb_a[n_done]}, {24'd0, bb_b[n_done]}, bb_ns[n_done]);
                check($sformatf("b2b_result_%0d", n_done), {24'd0, bus8.result}, exp[31:0]);
                check($sformatf("b2b_flag_%0d", n_done), {31'd0, bus8.flag}, {31'd0, exp[32]});
                n_done++;
            end
        end
        bus8.start = 1'b0;
        check("b2b_completed", n_done, 4);
        tick();
        tick();

        // Width sweep with random operands, including width extremes
        for (int i = 0; i < 4; i++) sweep_op(1, $urandom, $urandom, 1'($urandom));
        sweep_op(1, 32'h1, 32'h1, 1'b1);
        sweep_op(1, 32'h0, 32'h1, 1'b0);
        for (int i = 0; i < 6; i++) sweep_op(4, $urandom, $urandom, 1'($urandom));
        sweep_op(4, 32'hF, 32'h1, 1'b1);
        for (int i = 0; i < 6; i++) sweep_op(16, $urandom, $urandom, 1'($urandom));
        sweep_op(16, 32'h0000, 32'hFFFF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
